// File: rtl/alu_16_pkg.sv
// Shared definitions for the bit-serial 16-bit ALU: opcodes, widths, FSM states
// and the carry/borrow flag helper.
package alu_16_pkg;

  localparam int unsigned ALU_W = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic {StIdle, StBusy} state_e;

  // SUB runs as A + ~B + 1, so a borrow is the absence of a final carry.
  function automatic logic final_flag(input logic [2:0] op, input logic cout);
    case (op)
      OP_ADD:  final_flag = cout;
      OP_SUB:  final_flag = ~cout;
      default: final_flag = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice; the carry path is meaningful only for ADD/SUB.
module alu_bit_slice
  import alu_16_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       r,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    r     = 1'b0;
    cout  = 1'b0;
    b_eff = (op == OP_SUB) ? ~b : b;
    unique case (op)
      OP_ADD, OP_SUB: begin
        r    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (cin & (a ^ b_eff));
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_16.sv
// Bit-serial 16-bit ALU: one result bit per clock, LSB first, started by a
// synchronized rising edge of the asynchronous `on` button.
module alu_16
  import alu_16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               on,
  input  logic [ALU_W-1:0]   ina,
  input  logic [ALU_W-1:0]   inb,
  input  logic [2:0]         op,
  output logic [ALU_W:0]     out,
  output logic [CNT_W-1:0]   count
);

  state_e             state_q, state_d;
  logic               sync1_q, sync2_q, sync3_q;
  logic [ALU_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic               carry_q, carry_d;
  logic [ALU_W:0]     out_q, out_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               start;
  logic               slice_r, slice_cout;

  // sync3_q is the previous synchronized level, used only for edge detection.
  assign start = sync2_q & ~sync3_q & (state_q == StIdle);

  alu_bit_slice u_slice (
    .a    (a_q[count_q]),
    .b    (b_q[count_q]),
    .cin  (carry_q),
    .op   (op_q),
    .r    (slice_r),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    out_d   = out_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = ina;
          b_d     = inb;
          op_d    = op;
          carry_d = (op == OP_SUB);
          out_d   = '0;
          count_d = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        out_d[count_q] = slice_r;
        carry_d        = slice_cout;
        count_d        = count_q + 4'd1;
        if (count_q == 4'(ALU_W - 1)) begin
          out_d[ALU_W] = final_flag(op_q, slice_cout);
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      out_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= on;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      count_q <= count_d;
    end
  end

  assign out   = out_q;
  assign count = count_q;

endmodule

// File: tb/tb_alu_16.sv
// Self-checking bench for alu_16: directed operations, scoreboarded results,
// count sequencing, reset abort, busy-time disturbance and held-button cases.
module tb_alu_16;
  import alu_16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        on;
  logic [15:0] ina, inb;
  logic [2:0]  op;
  logic [16:0] out;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  alu_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .on    (on),
    .ina   (ina),
    .inb   (inb),
    .op    (op),
    .out   (out),
    .count (count)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] o);
    case (o)
      OP_ADD:  model = {1'b0, a} + {1'b0, b};
      OP_SUB:  model = {(a < b), 16'(a - b)};
      OP_AND:  model = {1'b0, a & b};
      OP_OR:   model = {1'b0, a | b};
      OP_XOR:  model = {1'b0, a ^ b};
      OP_NAND: model = {1'b0, ~(a & b)};
      OP_NOR:  model = {1'b0, ~(a | b)};
      default: model = {1'b0, ~(a ^ b)};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one operation from a negedge; returns at the negedge after edge S+16.
  // mode 0: normal pulse, 1: hold `on` high, 2: disturb inputs and `on` while busy.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] o, input int mode);
    logic [16:0] exp;
    ina = a;
    inb = b;
    op  = o;
    on  = 1'b1;
    exp_q.push_back(model(a, b, o));
    idle(3);
    for (int i = 0; i < 16; i++) begin
      chk({tag, " count"}, 17'(count), 17'(i));
      if (i == 0) chk({tag, " cleared"}, out, 17'h0);
      if (mode != 1 && i == 1) on = 1'b0;
      if (mode == 2) begin
        if (i == 4) begin
          ina = 16'h1234;
          inb = 16'h0000;
          op  = OP_ADD;
          on  = 1'b1;
        end
        if (i == 6) on = 1'b0;
        if (i == 8) on = 1'b1;
        if (i == 9) on = 1'b0;
      end
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    chk({tag, " result"}, out, exp);
    chk({tag, " count wrap"}, 17'(count), 17'h0);
    if (mode != 0) begin
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        chk({tag, " no restart"}, 17'(count), 17'h0);
        chk({tag, " held"}, out, exp);
      end
    end
    on = 1'b0;
    idle(4);
  endtask

  initial begin
    rst_n = 1'b0;
    on    = 1'b0;
    ina   = '0;
    inb   = '0;
    op    = OP_ADD;
    #1;
    chk("reset out", out, 17'h0);
    chk("reset count", 17'(count), 17'h0);
    idle(3);
    rst_n = 1'b1;
    idle(3);

    run_op("or", 16'h7003, 16'hC003, OP_OR, 0);
    chk("or value", out, 17'h0_F003);
    run_op("add", 16'h7003, 16'hC003, OP_ADD, 0);
    chk("add value", out, 17'h1_3006);
    run_op("add again", 16'h7003, 16'hC003, OP_ADD, 0);
    chk("add again value", out, 17'h1_3006);
    run_op("sub lt", 16'h0003, 16'h0005, OP_SUB, 0);
    chk("sub lt value", out, 17'h1_FFFE);
    run_op("sub gt", 16'h0005, 16'h0003, OP_SUB, 0);
    chk("sub gt value", out, 17'h0_0002);
    run_op("sub eq", 16'h8001, 16'h8001, OP_SUB, 0);
    run_op("add wrap", 16'hFFFF, 16'h0001, OP_ADD, 0);
    run_op("and", 16'hA5C3, 16'h0FF0, OP_AND, 0);
    run_op("nand", 16'hA5C3, 16'h0FF0, OP_NAND, 0);
    run_op("nor", 16'hA5C3, 16'h0FF0, OP_NOR, 0);
    run_op("xnor", 16'hA5C3, 16'h0FF0, OP_XNOR, 0);
    run_op("xor disturb", 16'hFFFF, 16'hFFFF, OP_XOR, 2);
    chk("xor value", out, 17'h0_0000);
    run_op("hold", 16'h1234, 16'h4321, OP_ADD, 1);
    chk("hold value", out, 17'h0_5555);

    // Reset in the middle of an operation aborts it with no partial result.
    ina = 16'hFFFF;
    inb = 16'h0000;
    op  = OP_OR;
    on  = 1'b1;
    idle(3);
    on = 1'b0;
    idle(6);
    chk("partial nonzero", 17'(out != 17'h0), 17'h1);
    rst_n = 1'b0;
    #1;
    chk("abort out", out, 17'h0);
    chk("abort count", 17'(count), 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post reset idle count", 17'(count), 17'h0);
      chk("post reset idle out", out, 17'h0);
    end
    run_op("after reset", 16'h00F0, 16'h0F00, OP_XOR, 0);
    chk("after reset value", out, 17'h0_0FF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
